// File: rtl/izh_neuron_array.sv
// izh_neuron_array: time-multiplexed Izhikevich neuron array sharing one
// synaptic accumulator and one fixed-point v/u update datapath.
module izh_neuron_array #(
    parameter int N_NEURONS = 16,
    parameter int N_INPUTS  = 32,
    parameter int WIDTH     = 16,
    parameter int FRAC      = 8,
    parameter int PA        = 5,
    parameter int PB        = 51,
    parameter int PC        = -16640,
    parameter int PD        = 2048,
    parameter int V_TH      = 7680,
    parameter bit WTA_EN    = 1'b0
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   START,
    input  logic [N_INPUTS-1:0]                    IN_SPIKE,
    input  logic                                   WE,
    input  logic [$clog2(N_NEURONS*N_INPUTS)-1:0]  WADDR,
    input  logic [WIDTH-1:0]                       WDATA,
    output logic                                   BUSY,
    output logic                                   DONE,
    output logic [N_NEURONS-1:0]                   SPIKE_OUT,
    output logic [15:0]                            SPIKE_CNT
);

    localparam int NW   = $clog2(N_NEURONS);
    localparam int KW   = $clog2(N_INPUTS);
    localparam int ACCW = WIDTH + KW;
    localparam int PW   = 2 * WIDTH + FRAC;

    localparam logic signed [PW-1:0] SMAX = PW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SMIN = -SMAX - PW'(1);
    localparam logic signed [PW-1:0] C04  = PW'((4 * (2 ** FRAC) + 50) / 100);
    localparam logic signed [PW-1:0] K140 = PW'(140 * (2 ** FRAC));
    localparam logic signed [PW-1:0] PAX  = PW'(PA);
    localparam logic signed [PW-1:0] PBX  = PW'(PB);
    localparam logic signed [PW-1:0] PDX  = PW'(PD);
    localparam logic signed [WIDTH-1:0] PCV = WIDTH'(PC);
    localparam logic signed [WIDTH-1:0] U0  = WIDTH'((PB * PC) >>> FRAC);
    localparam logic signed [WIDTH-1:0] VTH = WIDTH'(V_TH);

    typedef enum logic [2:0] {
        S_IDLE, S_ACC, S_UPD1, S_UPD2, S_WB, S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [N_INPUTS-1:0]      spk_q;
    logic [NW-1:0]            n_q;
    logic [KW:0]              k_q;
    logic signed [ACCW-1:0]   acc_q;
    logic signed [WIDTH-1:0]  v_q [N_NEURONS];
    logic signed [WIDTH-1:0]  u_q [N_NEURONS];
    logic signed [PW-1:0]     t1_q, t2_q, bv_q;
    logic signed [WIDTH-1:0]  vn_q, un_q;
    logic [N_NEURONS-1:0]     raw_q;
    logic [N_NEURONS-1:0]     spike_out_q;
    logic [15:0]              spike_cnt_q;

    logic signed [WIDTH-1:0]  mem [N_NEURONS*N_INPUTS];
    logic signed [WIDTH-1:0]  rdata_q;
    logic [NW+KW-1:0]         raddr;

    logic                     acc_end, last_n, fire;
    logic [KW-1:0]            kprev;
    logic [N_NEURONS-1:0]     raw_next;
    logic signed [PW-1:0]     vx, ux, ix, sq, t1, t2, bv, vsum, usum;

    function automatic logic signed [WIDTH-1:0] sat(
        input logic signed [PW-1:0] x
    );
        if (x > SMAX) return SMAX[WIDTH-1:0];
        if (x < SMIN) return SMIN[WIDTH-1:0];
        return WIDTH'(x);
    endfunction

    assign acc_end = (k_q == (KW+1)'(N_INPUTS));
    assign last_n  = (n_q == NW'(N_NEURONS - 1));
    assign kprev   = k_q[KW-1:0] - KW'(1);
    assign raddr   = {n_q, k_q[KW-1:0]};
    assign fire    = (vn_q >= VTH);
    assign raw_next = raw_q | (fire ? (N_NEURONS'(1) << n_q) : '0);

    // Datapath arithmetic on the currently selected neuron.
    assign vx   = PW'(v_q[n_q]);
    assign ux   = PW'(u_q[n_q]);
    assign ix   = PW'(sat(PW'(acc_q)));
    assign sq   = (vx * vx) >>> FRAC;
    assign t1   = (sq * C04) >>> FRAC;
    assign t2   = vx * PW'(5);
    assign bv   = (PBX * vx) >>> FRAC;
    assign vsum = vx + t1_q + t2_q + K140 - ux + ix;
    assign usum = ux + ((PAX * (bv_q - ux)) >>> FRAC);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_ACC;
            S_ACC:   if (acc_end) state_d = S_UPD1;
            S_UPD1:  state_d = S_UPD2;
            S_UPD2:  state_d = S_WB;
            S_WB:    state_d = last_n ? S_FIN : S_ACC;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state_q)
            S_IDLE:  ;
            S_FIN:   DONE = 1'b1;
            default: BUSY = 1'b1;
        endcase
    end

    // Weight RAM: registered read returns pre-write data on collision.
    always_ff @(posedge CLK) begin
        if (WE) mem[WADDR] <= WDATA;
        rdata_q <= mem[raddr];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            spk_q       <= '0;
            n_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            bv_q        <= '0;
            vn_q        <= '0;
            un_q        <= '0;
            raw_q       <= '0;
            spike_out_q <= '0;
            spike_cnt_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i] <= PCV;
                u_q[i] <= U0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        spk_q <= IN_SPIKE;
                        n_q   <= '0;
                        k_q   <= '0;
                        acc_q <= '0;
                        raw_q <= '0;
                    end
                end
                S_ACC: begin
                    k_q <= k_q + (KW+1)'(1);
                    // Read data for input k-1 arrives this cycle.
                    if (k_q != '0 && spk_q[kprev])
                        acc_q <= acc_q + ACCW'(rdata_q);
                end
                S_UPD1: begin
                    t1_q <= t1;
                    t2_q <= t2;
                    bv_q <= bv;
                end
                S_UPD2: begin
                    vn_q <= sat(vsum);
                    un_q <= sat(usum);
                end
                S_WB: begin
                    if (fire) begin
                        v_q[n_q]    <= PCV;
                        u_q[n_q]    <= sat(PW'(un_q) + PDX);
                        spike_cnt_q <= spike_cnt_q + 16'd1;
                    end else begin
                        v_q[n_q] <= vn_q;
                        u_q[n_q] <= un_q;
                    end
                    raw_q <= raw_next;
                    n_q   <= n_q + NW'(1);
                    k_q   <= '0;
                    acc_q <= '0;
                    if (last_n)
                        spike_out_q <= WTA_EN
                            ? (raw_next & (~raw_next + N_NEURONS'(1)))
                            : raw_next;
                end
                default: ;
            endcase
        end
    end

    assign SPIKE_OUT = spike_out_q;
    assign SPIKE_CNT = spike_cnt_q;

endmodule
